// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for pll_supervisor: FSM state encodings, status-counter
// saturation limits and saturating-increment helpers.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_PULSE = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABILIZE = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam logic [7:0] LOSS_CNT_MAX  = 8'hFF;
  localparam logic [3:0] RETRY_CNT_MAX = 4'hF;

  function automatic logic [7:0] sat_inc_loss(input logic [7:0] v);
    return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc_retry(input logic [3:0] v);
    return (v == RETRY_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pll_core_wrap.sv
// Thin wrapper around the iCE40 SB_PLL40_CORE primitive. Builds with SYNTHESIS
// defined get the real primitive; other builds get a pass-through stand-in.
module pll_core_wrap #(
  parameter logic [3:0] DIVR         = 4'd2,
  parameter logic [6:0] DIVF         = 7'd49,
  parameter logic [2:0] DIVQ         = 3'd2,
  parameter logic [2:0] FILTER_RANGE = 3'd1
) (
  input  logic clock_in,
  input  logic resetb,
  output logic clock_out,
  output logic lock
);

`ifdef SYNTHESIS
  SB_PLL40_CORE #(
    .FEEDBACK_PATH("SIMPLE"),
    .DIVR         (DIVR),
    .DIVF         (DIVF),
    .DIVQ         (DIVQ),
    .FILTER_RANGE (FILTER_RANGE)
  ) u_pll (
    .REFERENCECLK    (clock_in),
    .PLLOUTCORE      (clock_out),
    .PLLOUTGLOBAL    (),
    .EXTFEEDBACK     (1'b0),
    .DYNAMICDELAY    (8'h00),
    .LOCK            (lock),
    .BYPASS          (1'b0),
    .RESETB          (resetb),
    .LATCHINPUTVALUE (1'b0),
    .SDO             (),
    .SDI             (1'b0),
    .SCLK            (1'b0)
  );
`else
  // Stand-in: output follows the reference while out of reset, lock follows resetb.
  logic [16:0] unused_cfg;
  assign unused_cfg = {DIVR, DIVF, DIVQ, FILTER_RANGE};
  assign clock_out  = clock_in & resetb;
  assign lock       = resetb;
`endif

endmodule

// File: rtl/pll_supervisor.sv
// Supervises an iCE40 PLL from the reference domain: drives RESETB, qualifies
// LOCK, retries on timeout. Optional macro PLL_SUPERVISOR_AUTORETRY_EN relocks after lock loss.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter logic [3:0] DIVR                = 4'd2,
  parameter logic [6:0] DIVF                = 7'd49,
  parameter logic [2:0] DIVQ                = 3'd2,
  parameter logic [2:0] FILTER_RANGE        = 3'd1,
  parameter int         RESET_PULSE_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT_CYCLES = 4800,
  parameter int         LOCK_STABLE_CYCLES  = 480,
  parameter int         MAX_RETRIES         = 3,
  parameter int         CNT_W               = 16
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       enable,
  output logic       clock_out,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [7:0] lock_loss_count,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             pll_resetb;
  logic             pll_lock;
  logic             lock_meta;
  logic             lock_s;

  pll_core_wrap #(
    .DIVR         (DIVR),
    .DIVF         (DIVF),
    .DIVQ         (DIVQ),
    .FILTER_RANGE (FILTER_RANGE)
  ) u_core (
    .clock_in  (clock_in),
    .resetb    (pll_resetb),
    .clock_out (clock_out),
    .lock      (pll_lock)
  );

  // NOTE: non-blocking assignments make lock_s take the previous lock_meta,
  // so the two flops really form two stages.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state           <= ST_IDLE;
      counter         <= '0;
      pll_resetb      <= 1'b0;
      pll_ready       <= 1'b0;
      pll_fail        <= 1'b0;
      lock_loss_count <= '0;
      retry_count     <= '0;
    end else if (!enable) begin
      // lock_loss_count survives an enable drop; only reset clears it.
      state      <= ST_IDLE;
      counter    <= '0;
      pll_resetb <= 1'b0;
      pll_ready  <= 1'b0;
      pll_fail   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state       <= ST_RST_PULSE;
          counter     <= '0;
          retry_count <= 4'd1;
          pll_resetb  <= 1'b0;
        end

        ST_RST_PULSE: begin
          if (counter == PULSE_LAST) begin
            state      <= ST_WAIT_LOCK;
            counter    <= '0;
            pll_resetb <= 1'b1;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins.
          if (lock_s) begin
            state   <= ST_STABILIZE;
            counter <= '0;
          end else if (counter == TIMEOUT_LAST) begin
            counter    <= '0;
            pll_resetb <= 1'b0;
            if (int'(retry_count) < MAX_RETRIES) begin
              state       <= ST_RST_PULSE;
              retry_count <= sat_inc_retry(retry_count);
            end else begin
              state    <= ST_FAIL;
              pll_fail <= 1'b1;
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        ST_STABILIZE: begin
          if (!lock_s) begin
            counter <= '0;
          end else if (counter == STABLE_LAST) begin
            state     <= ST_READY;
            counter   <= '0;
            pll_ready <= 1'b1;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        ST_READY: begin
          if (!lock_s) begin
            counter         <= '0;
            pll_ready       <= 1'b0;
            pll_resetb      <= 1'b0;
            lock_loss_count <= sat_inc_loss(lock_loss_count);
`ifdef PLL_SUPERVISOR_AUTORETRY_EN
            state       <= ST_RST_PULSE;
            retry_count <= 4'd1;
`else
            state    <= ST_FAIL;
            pll_fail <= 1'b1;
`endif
          end
        end

        ST_FAIL: begin
          pll_resetb <= 1'b0;
          pll_ready  <= 1'b0;
          pll_fail   <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          counter    <= '0;
          pll_resetb <= 1'b0;
          pll_ready  <= 1'b0;
          pll_fail   <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with small timing parameters; LOCK is
// driven by forcing the PLL stand-in's lock net.
module tb_pll_supervisor;

  logic       clock_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       clock_out;
  logic       pll_ready;
  logic       pll_fail;
  logic [7:0] lock_loss_count;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock_in = ~clock_in;

  pll_supervisor #(
    .RESET_PULSE_CYCLES  (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (3)
  ) dut (
    .clock_in        (clock_in),
    .reset           (reset),
    .enable          (enable),
    .clock_out       (clock_out),
    .pll_ready       (pll_ready),
    .pll_fail        (pll_fail),
    .lock_loss_count (lock_loss_count),
    .retry_count     (retry_count),
    .state_dbg       (state_dbg)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       lk;
    int         cycles;
    logic [2:0] st;
    logic       rb;
    logic       rdy;
    logic       fl;
    logic [3:0] rt;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic lk, input int cyc,
                              input logic [2:0] st, input logic rb, input logic rdy,
                              input logic fl, input logic [3:0] rt, input logic [7:0] loss);
    vec_t v;
    v.rst = rst; v.en = en; v.lk = lk; v.cycles = cyc;
    v.st = st; v.rb = rb; v.rdy = rdy; v.fl = fl; v.rt = rt; v.loss = loss;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_lock(input logic v);
    if (v) force dut.pll_lock = 1'b1;
    else   force dut.pll_lock = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state_dbg != target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(state_dbg), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_t[$];
    int fall_t[$];
    logic prev_rb;
    logic sat_ok;

    reset  = 1'b1;
    enable = 1'b0;
    set_lock(1'b0);

    // Nominal lock, then a lock loss from READY, then enable drop and restart.
    vecs.push_back(mk(1, 0, 0, 2, 3'd0, 0, 0, 0, 4'd0, 8'd0));
    vecs.push_back(mk(0, 1, 0, 1, 3'd1, 0, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 0, 3, 3'd1, 0, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 0, 1, 3'd2, 1, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 0, 9, 3'd2, 1, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 1, 2, 3'd2, 1, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 1, 1, 3'd3, 1, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 1, 7, 3'd3, 1, 0, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 1, 1, 3'd4, 1, 1, 0, 4'd1, 8'd0));
    vecs.push_back(mk(0, 1, 0, 2, 3'd4, 1, 1, 0, 4'd1, 8'd0));
`ifdef PLL_SUPERVISOR_AUTORETRY_EN
    vecs.push_back(mk(0, 1, 0, 1, 3'd1, 0, 0, 0, 4'd1, 8'd1));
`else
    vecs.push_back(mk(0, 1, 0, 1, 3'd5, 0, 0, 1, 4'd1, 8'd1));
`endif
    vecs.push_back(mk(0, 0, 0, 1, 3'd0, 0, 0, 0, 4'd1, 8'd1));
    vecs.push_back(mk(0, 1, 0, 1, 3'd1, 0, 0, 0, 4'd1, 8'd1));

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      set_lock(vecs[i].lk);
      repeat (vecs[i].cycles) tick();
      check($sformatf("v%0d_state", i),  32'(state_dbg),       32'(vecs[i].st));
      check($sformatf("v%0d_resetb", i), 32'(dut.pll_resetb),  32'(vecs[i].rb));
      check($sformatf("v%0d_ready", i),  32'(pll_ready),       32'(vecs[i].rdy));
      check($sformatf("v%0d_fail", i),   32'(pll_fail),        32'(vecs[i].fl));
      check($sformatf("v%0d_retry", i),  32'(retry_count),     32'(vecs[i].rt));
      check($sformatf("v%0d_loss", i),   32'(lock_loss_count), 32'(vecs[i].loss));
    end

    // Reset while waiting for lock clears everything, including lock_loss_count.
    repeat (4) tick();
    check("rst_pre_state", 32'(state_dbg), 32'd2);
    check("rst_pre_loss", 32'(lock_loss_count), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_resetb", 32'(dut.pll_resetb), 32'd0);
    check("rst_ready", 32'(pll_ready), 32'd0);
    check("rst_fail", 32'(pll_fail), 32'd0);
    check("rst_retry", 32'(retry_count), 32'd0);
    check("rst_loss", 32'(lock_loss_count), 32'd0);
    reset = 1'b0;

    // LOCK never rises: three 20-cycle RESETB-high windows spaced 24 apart, then FAIL.
    prev_rb = dut.pll_resetb;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dut.pll_resetb && !prev_rb) rise_t.push_back(i);
      if (!dut.pll_resetb && prev_rb) fall_t.push_back(i);
      prev_rb = dut.pll_resetb;
    end
    check("to_rise_count", 32'(rise_t.size()), 32'd3);
    check("to_fall_count", 32'(fall_t.size()), 32'd3);
    if (rise_t.size() == 3 && fall_t.size() == 3) begin
      check("to_rise_gap0", 32'(rise_t[1] - rise_t[0]), 32'd24);
      check("to_rise_gap1", 32'(rise_t[2] - rise_t[1]), 32'd24);
      for (int k = 0; k < 3; k++)
        check($sformatf("to_high_len%0d", k), 32'(fall_t[k] - rise_t[k]), 32'd20);
      check("to_low_len0", 32'(rise_t[1] - fall_t[0]), 32'd4);
    end
    check("to_state", 32'(state_dbg), 32'd5);
    check("to_fail", 32'(pll_fail), 32'd1);
    check("to_retry", 32'(retry_count), 32'd3);
    check("to_resetb", 32'(dut.pll_resetb), 32'd0);

    // Leave FAIL by toggling enable.
    enable = 1'b0;
    tick();
    check("tog_off_state", 32'(state_dbg), 32'd0);
    check("tog_off_fail", 32'(pll_fail), 32'd0);
    enable = 1'b1;
    tick();
    check("tog_on_state", 32'(state_dbg), 32'd1);
    check("tog_on_retry", 32'(retry_count), 32'd1);

    // lock_s arrives on the very cycle the timeout expires: lock must win.
    wait_state(3'd2, 10, "tie_wait_wl");
    repeat (17) tick();
    set_lock(1'b1);
    tick();
    tick();
    check("tie_pre_state", 32'(state_dbg), 32'd2);
    tick();
    check("tie_state", 32'(state_dbg), 32'd3);
    check("tie_retry", 32'(retry_count), 32'd1);

    // One-cycle LOCK glitch during STABILIZE restarts the stable count.
    repeat (3) tick();
    set_lock(1'b0);
    tick();
    set_lock(1'b1);
    tick();
    tick();
    check("gl_restart_state", 32'(state_dbg), 32'd3);
    repeat (7) tick();
    check("gl_pre_state", 32'(state_dbg), 32'd3);
    check("gl_pre_ready", 32'(pll_ready), 32'd0);
    tick();
    check("gl_state", 32'(state_dbg), 32'd4);
    check("gl_ready", 32'(pll_ready), 32'd1);
    check("gl_retry", 32'(retry_count), 32'd1);

    // Lock loss while READY.
    set_lock(1'b0);
    repeat (3) tick();
    check("ll_ready", 32'(pll_ready), 32'd0);
    check("ll_loss", 32'(lock_loss_count), 32'd1);
    check("ll_resetb", 32'(dut.pll_resetb), 32'd0);
`ifdef PLL_SUPERVISOR_AUTORETRY_EN
    check("ll_state", 32'(state_dbg), 32'd1);
    check("ll_retry", 32'(retry_count), 32'd1);
    repeat (3) tick();
    check("ll_pulse_low", 32'(dut.pll_resetb), 32'd0);
    tick();
    check("ll_pulse_end", 32'(dut.pll_resetb), 32'd1);
`else
    check("ll_state", 32'(state_dbg), 32'd5);
    check("ll_fail", 32'(pll_fail), 32'd1);
`endif

    // Repeated lock losses: the counter must stop at 255.
    sat_ok = 1'b1;
    for (int it = 0; it < 260; it++) begin
      int n;
      set_lock(1'b1);
      if (state_dbg == 3'd5) begin
        enable = 1'b0;
        tick();
        enable = 1'b1;
      end
      n = 0;
      while (!pll_ready && n < 60) begin
        tick();
        n++;
      end
      if (!pll_ready) sat_ok = 1'b0;
      set_lock(1'b0);
      repeat (3) tick();
    end
    check("sat_relock", 32'(sat_ok), 32'd1);
    check("sat_loss", 32'(lock_loss_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
